// File: rtl/bus_mem_ctrl.sv
// bus_mem_ctrl: memory-side bus target for the CPU external bus.
// Captures one access, inserts WAIT_CYCLES wait states, then commits a write
// to or returns a read from an internal word-addressed RAM. The CPU is
// stalled through o_lock while an access is in flight. An address with any
// bit set above the RAM index range completes with the same timing and
// raises o_err.
//
// Ports:
//   clk        - system clock, rising edge
//   rst        - synchronous reset, active-high
//   i_cs       - access request, sampled in IDLE or DONE
//   i_rw       - 0 = read, 1 = write
//   i_addr     - word address
//   i_wdata    - write data
//   o_rdata    - read data, holds the last read result
//   o_rdata_oe - drive enable for o_rdata (DONE of a read)
//   o_lock     - CPU stall request
//   o_ready    - one-cycle completion pulse
//   o_err      - one-cycle out-of-range pulse alongside o_ready
module bus_mem_ctrl #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_AW      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cs,
  input  logic              i_rw,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rdata_oe,
  output logic              o_lock,
  output logic              o_ready,
  output logic              o_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [3:0]        cnt_r;
  logic [MEM_AW-1:0] addr_r;
  logic              rw_r;
  logic [DATA_W-1:0] wdata_r;
  logic              oor_r;
  logic              capture_s;
  logic              fire_s;

  logic [DATA_W-1:0] mem [0:(1<<MEM_AW)-1];

  // Out of range when any address bit above the RAM index is set.
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return |a[ADDR_W-1:MEM_AW];
  endfunction

  // Request acceptance and access-commit strobes.
  always_comb begin
    capture_s = i_cs & ((state_r == IDLE) | (state_r == DONE));
    fire_s    = (state_r == ACCESS) & (cnt_r == 4'd0);
  end

  // Next-state decode and the combinational stall line.
  always_comb begin
    state_nxt_s = state_r;
    o_lock      = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_cs) state_nxt_s = ACCESS;
        else      state_nxt_s = IDLE;
        o_lock = i_cs & ~rst;
      end
      ACCESS: begin
        if (cnt_r == 4'd0) state_nxt_s = DONE;
        else               state_nxt_s = ACCESS;
        o_lock = ~rst;
      end
      DONE: begin
        // Back-to-back request goes straight to ACCESS with no IDLE bubble.
        if (i_cs) state_nxt_s = ACCESS;
        else      state_nxt_s = IDLE;
        o_lock = i_cs & ~rst;
      end
      default: begin
        state_nxt_s = IDLE;
        o_lock      = 1'b0;
      end
    endcase
  end

  // State, capture registers, wait counter and registered bus outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      addr_r     <= '0;
      rw_r       <= 1'b0;
      wdata_r    <= '0;
      oor_r      <= 1'b0;
      o_rdata    <= '0;
      o_rdata_oe <= 1'b0;
      o_ready    <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (capture_s) begin
        addr_r  <= i_addr[MEM_AW-1:0];
        rw_r    <= i_rw;
        wdata_r <= i_wdata;
        oor_r   <= out_of_range(i_addr);
        cnt_r   <= WAIT_LD;
      end else if ((state_r == ACCESS) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
      // Reads update o_rdata; writes leave the previous read result held.
      if (fire_s && !rw_r) begin
        o_rdata <= oor_r ? '0 : mem[addr_r];
      end
      // Completion flags are high exactly during the DONE cycle.
      o_ready    <= fire_s;
      o_err      <= fire_s & oor_r;
      o_rdata_oe <= fire_s & ~rw_r;
    end
  end

  // RAM write port; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (fire_s && rw_r && !oor_r && !rst) begin
      mem[addr_r] <= wdata_r;
    end
  end

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Self-checking bench for bus_mem_ctrl: a WAIT_CYCLES=2 instance (A) and a
// WAIT_CYCLES=0 instance (B) share clock and reset. Inputs are driven and
// outputs sampled on the falling edge.
module tb_bus_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_cs, a_rw, b_cs, b_rw;
  logic [15:0] a_addr, a_wdata, b_addr, b_wdata;
  logic [15:0] a_rdata, b_rdata;
  logic        a_oe, a_lock, a_ready, a_err;
  logic        b_oe, b_lock, b_ready, b_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: RAM image and the last read result of instance A.
  logic [15:0] mem_m [0:1023];
  logic [15:0] last_rd;

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        exp_err;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  bus_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_AW(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(rst), .i_cs(a_cs), .i_rw(a_rw), .i_addr(a_addr),
    .i_wdata(a_wdata), .o_rdata(a_rdata), .o_rdata_oe(a_oe),
    .o_lock(a_lock), .o_ready(a_ready), .o_err(a_err));

  bus_mem_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_AW(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .i_cs(b_cs), .i_rw(b_rw), .i_addr(b_addr),
    .i_wdata(b_wdata), .o_rdata(b_rdata), .o_rdata_oe(b_oe),
    .o_lock(b_lock), .o_ready(b_ready), .o_err(b_err));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected outcome of one access from the bus rules, then model update.
  task automatic model_step(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                            output logic [15:0] exp_rd, output logic exp_err);
    exp_err = (addr >= 16'd1024);
    if (rw) begin
      if (!exp_err) mem_m[addr[9:0]] = wdata;
    end else begin
      last_rd = exp_err ? 16'h0000 : mem_m[addr[9:0]];
    end
    exp_rd = last_rd;
  endtask

  // One single-cycle request on instance A (sel=0) or B (sel=1); checks
  // lock, latency, pulse width and returns rdata/err seen in DONE.
  task automatic do_access(input logic sel, input logic rw, input logic [15:0] addr,
                           input logic [15:0] wdata, output logic [15:0] rd, output logic er);
    int lat;
    logic got;
    int exp_lat;
    exp_lat = sel ? 2 : 4;
    @(negedge clk);
    if (sel) begin b_cs = 1'b1; b_rw = rw; b_addr = addr; b_wdata = wdata; end
    else     begin a_cs = 1'b1; a_rw = rw; a_addr = addr; a_wdata = wdata; end
    #1;
    check("lock_on_request", sel ? b_lock : a_lock, 1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (sel ? b_ready : a_ready) got = 1'b1;
      else check("lock_while_busy", sel ? b_lock : a_lock, 1);
      if (lat == 1) begin
        // Bus lines change after capture; the access must ignore them.
        if (sel) begin b_cs = 1'b0; b_rw = ~rw; b_addr = 16'($urandom); b_wdata = 16'($urandom); end
        else     begin a_cs = 1'b0; a_rw = ~rw; a_addr = 16'($urandom); a_wdata = 16'($urandom); end
      end
    end
    check("ready_seen", got, 1);
    check("latency", lat, exp_lat);
    rd = sel ? b_rdata : a_rdata;
    er = sel ? b_err : a_err;
    check("oe_in_done", sel ? b_oe : a_oe, !rw);
    check("lock_in_done", sel ? b_lock : a_lock, 0);
    @(negedge clk);
    check("ready_width", sel ? b_ready : a_ready, 0);
    check("err_after_done", sel ? b_err : a_err, 0);
    check("oe_after_done", sel ? b_oe : a_oe, 0);
  endtask

  initial begin
    logic [15:0] rd, exp_rd, a;
    logic        er, exp_err, rw;

    tbl[0] = '{1'b1, 16'h0000, 16'h5A5A, 16'h0000, 1'b0};
    tbl[1] = '{1'b1, 16'h0005, 16'h1234, 16'h0000, 1'b0};
    tbl[2] = '{1'b0, 16'h0005, 16'h0000, 16'h1234, 1'b0};
    tbl[3] = '{1'b1, 16'h0400, 16'hBEEF, 16'h1234, 1'b1};
    tbl[4] = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b0};
    tbl[5] = '{1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1};
    tbl[6] = '{1'b1, 16'h03FF, 16'h0F0F, 16'h0000, 1'b0};
    tbl[7] = '{1'b0, 16'h03FF, 16'h0000, 16'h0F0F, 1'b0};

    last_rd = 16'h0000;
    rst = 1'b1;
    a_cs = 1'b1; a_rw = 1'b0; a_addr = 16'h0; a_wdata = 16'h0;
    b_cs = 1'b1; b_rw = 1'b0; b_addr = 16'h0; b_wdata = 16'h0;

    // Reset: outputs zero and lock suppressed even with a request present.
    repeat (3) @(negedge clk);
    check("rst_rdata_a", a_rdata, 0);
    check("rst_flags_a", {a_ready, a_err, a_oe, a_lock}, 0);
    check("rst_rdata_b", b_rdata, 0);
    check("rst_flags_b", {b_ready, b_err, b_oe, b_lock}, 0);
    rst = 1'b0; a_cs = 1'b0; b_cs = 1'b0;
    @(negedge clk);
    check("idle_flags_a", {a_ready, a_err, a_oe, a_lock}, 0);

    // Directed vector table on instance A.
    for (int i = 0; i < 8; i++) begin
      do_access(1'b0, tbl[i].rw, tbl[i].addr, tbl[i].wdata, rd, er);
      model_step(tbl[i].rw, tbl[i].addr, tbl[i].wdata, exp_rd, exp_err);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
    end

    // Randomized traffic against the model: fill 0..31, then mixed ops.
    for (int i = 0; i < 72; i++) begin
      if (i < 32) begin
        rw = 1'b1; a = 16'(i);
      end else begin
        rw = 1'($urandom);
        a = ($urandom_range(0, 7) == 0) ? (16'h0400 | 16'($urandom))
                                        : 16'($urandom_range(0, 31));
      end
      exp_rd = 16'($urandom);
      do_access(1'b0, rw, a, exp_rd, rd, er);
      model_step(rw, a, exp_rd, exp_rd, exp_err);
      check("rand_rdata", rd, exp_rd);
      check("rand_err", er, exp_err);
    end

    // Back-to-back reads of 0x0001 then 0x0002 with i_cs held across DONE.
    @(negedge clk);
    a_cs = 1'b1; a_rw = 1'b0; a_addr = 16'h0001;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      check($sformatf("b2b_ready_k%0d", k), a_ready, (k == 4) || (k == 8));
      check($sformatf("b2b_lock_k%0d", k), a_lock, k < 8);
      if (k == 4) check("b2b_rdata1", a_rdata, mem_m[1]);
      if (k == 8) check("b2b_rdata2", a_rdata, mem_m[2]);
      if (k == 1) a_addr = 16'h0002;
      if (k == 5) a_cs = 1'b0;
    end
    last_rd = mem_m[2];

    // Reset in the 2nd ACCESS cycle of a write: write must not commit.
    do_access(1'b0, 1'b1, 16'h0010, 16'h1111, rd, er);
    model_step(1'b1, 16'h0010, 16'h1111, exp_rd, exp_err);
    @(negedge clk);
    a_cs = 1'b1; a_rw = 1'b1; a_addr = 16'h0010; a_wdata = 16'hAAAA;
    @(negedge clk);
    a_cs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_rdata", a_rdata, 0);
    check("midrst_flags", {a_ready, a_err, a_oe, a_lock}, 0);
    rst = 1'b0;
    last_rd = 16'h0000;
    @(negedge clk);
    check("midrst_idle", {a_ready, a_err, a_oe, a_lock}, 0);
    do_access(1'b0, 1'b0, 16'h0010, 16'h0000, rd, er);
    model_step(1'b0, 16'h0010, 16'h0000, exp_rd, exp_err);
    check("midrst_readback", rd, 16'h1111);
    check("midrst_model", rd, exp_rd);

    // WAIT_CYCLES=0 instance: latency 2, post-capture input changes ignored.
    do_access(1'b1, 1'b1, 16'h0003, 16'h00AB, rd, er);
    check("w0_write_err", er, 0);
    check("w0_write_hold", rd, 16'h0000);
    do_access(1'b1, 1'b0, 16'h0003, 16'h0000, rd, er);
    check("w0_read", rd, 16'h00AB);
    check("w0_read_err", er, 0);
    do_access(1'b1, 1'b0, 16'h8003, 16'h0000, rd, er);
    check("w0_oor_read", rd, 16'h0000);
    check("w0_oor_err", er, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
